// File: rtl/spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// spi_master_arbiter
//
// Purpose:
//   This block lets N_REQ requesters share one spi_logic_master, one transfer
//   at a time, with round-robin grants. For each grant it does the following:
//     - loads the bitrate, TX word and control word into the master
//       registers,
//     - pulses the start bit for START_HOLD cycles,
//     - waits for a rising edge of IRQ_SPI,
//     - returns SPI_DATA_IN to the owner with a one-cycle rsp_valid pulse.
//
// Ports:
//   clk_cpu       system clock, rising edge
//   rst           asynchronous active-high reset
//   req_valid     per-requester request level
//   req_data      32-bit TX word per requester (slice i = requester i)
//   req_ctrl      9-bit control word per requester (bit 1 ignored)
//   req_bitrate   32-bit bitrate divisor per requester
//   grant         one-hot current owner, 0 when idle
//   rsp_valid     one-cycle completion pulse to the owner
//   rsp_data      received word, qualified by rsp_valid
//   rsp_err       timeout flag, qualified by rsp_valid
//   SPI_BITRATE   bitrate register of the master
//   SPI_DATA_OUT  TX data register of the master
//   SPI_CTRL      control register of the master (bit 1 = start)
//   SPI_DATA_IN   RX data from the master
//   IRQ_SPI       completion level from the master
//
// Build option:
//   SPI_ARB_TIMEOUT_EN - adds a WAIT watchdog of TIMEOUT_CYCLES cycles.
//   When the watchdog expires, the transfer completes with rsp_err=1 and
//   rsp_data=0.
//
// All outputs are registered from the current state. This is why the grant
// and the SETUP register values appear one edge after the FSM enters SETUP.
// ---------------------------------------------------------------------------
module spi_master_arbiter #(
  parameter int N_REQ          = 4,
  parameter int START_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_cpu,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_data,
  input  logic [9*N_REQ-1:0]    req_ctrl,
  input  logic [32*N_REQ-1:0]   req_bitrate,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic [31:0]           SPI_BITRATE,
  output logic [31:0]           SPI_DATA_OUT,
  output logic [8:0]            SPI_CTRL,
  input  logic [31:0]           SPI_DATA_IN,
  input  logic                  IRQ_SPI
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(START_HOLD + 1);
  localparam logic [PW:0]   N_W       = (PW+1)'(N_REQ);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [8:0]    START_BIT = 9'b000000010;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     gsel_q, gsel_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       br_q, br_d;
  logic [31:0]       dout_q, dout_d;
  logic [8:0]        ctrl_q, ctrl_d;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]     tmo_q, tmo_d;
`else
  logic              unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // Unpack the flat request buses into per-requester slices.
  logic [31:0] data_s [N_REQ];
  logic [31:0] br_s   [N_REQ];
  logic [8:0]  ctrl_s [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign data_s[gi] = req_data[gi*32 +: 32];
      assign br_s[gi]   = req_bitrate[gi*32 +: 32];
      assign ctrl_s[gi] = req_ctrl[gi*9 +: 9];
    end
  endgenerate

  logic [N_REQ-1:0] gsel_onehot;
  assign gsel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << gsel_q;

  // Round-robin pick: first set request at or after rr_ptr, with wrap-around.
  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [PW:0]   cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!pick_found && req_valid[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gsel_d      = gsel_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    irq_d       = IRQ_SPI;
    err_d       = err_q;
    grant_d     = grant_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    br_d        = br_q;
    dout_d      = dout_q;
    ctrl_d      = ctrl_q;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        ctrl_d  = '0;
        err_d   = 1'b0;
        if (pick_found) begin
          gsel_d  = pick_idx;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // The granted requester's inputs are sampled only here. After this
        // point, the master registers hold their values on their own.
        grant_d = gsel_onehot;
        br_d    = br_s[gsel_q];
        dout_d  = data_s[gsel_q];
        ctrl_d  = ctrl_s[gsel_q] & ~START_BIT;
        hold_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        ctrl_d = ctrl_q | START_BIT;
        if (hold_q == HOLD_LAST) begin
          state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_WAIT: begin
        ctrl_d = ctrl_q & ~START_BIT;
        // Edge detect, so that an IRQ level left over from an earlier
        // transfer cannot complete this one.
        if (IRQ_SPI && !irq_q) begin
          state_d = S_DONE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        grant_d     = '0;
        ctrl_d      = '0;
        rsp_valid_d = gsel_onehot;
        rsp_data_d  = err_q ? 32'd0 : SPI_DATA_IN;
        rsp_err_d   = err_q;
        rr_ptr_d    = (gsel_q == LAST_IDX) ? '0 : gsel_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gsel_q      <= '0;
      rr_ptr_q    <= '0;
      hold_q      <= '0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      br_q        <= '0;
      dout_q      <= '0;
      ctrl_q      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gsel_q      <= gsel_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      br_q        <= br_d;
      dout_q      <= dout_d;
      ctrl_q      <= ctrl_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign SPI_BITRATE  = br_q;
  assign SPI_DATA_OUT = dout_q;
  assign SPI_CTRL     = ctrl_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Purpose:
//   Self-checking bench for spi_master_arbiter (N_REQ=4, START_HOLD=2,
//   TIMEOUT_CYCLES=16).
//
// Structure:
//   - A table of request phases drives concurrent requests. The expected
//     grant order of each phase is pushed into a scoreboard queue, and each
//     entry is popped when the DUT grants.
//   - Hand-written sequences cover the stale IRQ, the drop during a
//     transfer, reset in WAIT and the timeout behaviour. The timeout
//     behaviour follows SPI_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_spi_master_arbiter;
  localparam int N   = 4;
  localparam int SH  = 2;
  localparam int TMO = 16;

  logic             clk_cpu = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [32*N-1:0]  req_data;
  logic [9*N-1:0]   req_ctrl;
  logic [32*N-1:0]  req_bitrate;
  logic [N-1:0]     grant;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic [31:0]      SPI_BITRATE;
  logic [31:0]      SPI_DATA_OUT;
  logic [8:0]       SPI_CTRL;
  logic [31:0]      SPI_DATA_IN;
  logic             IRQ_SPI;

  spi_master_arbiter #(.N_REQ(N), .START_HOLD(SH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ctrl(req_ctrl), .req_bitrate(req_bitrate), .grant(grant),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .SPI_BITRATE(SPI_BITRATE), .SPI_DATA_OUT(SPI_DATA_OUT), .SPI_CTRL(SPI_CTRL),
    .SPI_DATA_IN(SPI_DATA_IN), .IRQ_SPI(IRQ_SPI)
  );

  initial forever #5 clk_cpu = ~clk_cpu;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  logic [31:0] data_t [N];
  logic [31:0] br_t   [N];
  logic [31:0] din_t  [N];
  logic [8:0]  ctrl_t [N];

  typedef struct {
    bit         rst_first;
    logic [3:0] mask;
    logic [3:0] rereq;
    int         n;
    logic [7:0] order;   // 2-bit requester indices, first grant in [1:0]
  } phase_t;
  phase_t ph [4];

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant == '0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // One full transfer for the next scoreboard entry. The requester drops
  // req_valid as soon as its response is seen.
  task automatic do_xfer(input bit stale, input bit drop, output int g);
    int n;
    logic [8:0] c;
    g = 0;
    if (exp_q.size() == 0) return;
    g = exp_q.pop_front();
    wait_grant(n);
    chk("grant_latency", n, 2);
    if (n >= 40) begin
      req_valid[g] = 1'b0;
      return;
    end
    chk("grant", {28'd0, grant}, 32'd1 << g);
    chk("setup_data", SPI_DATA_OUT, data_t[g]);
    chk("setup_bitrate", SPI_BITRATE, br_t[g]);
    c = ctrl_t[g] & 9'h1FD;
    chk("setup_ctrl", {23'd0, SPI_CTRL}, {23'd0, c});
    for (int h = 0; h < SH; h++) begin
      tick();
      chk("start_ctrl", {23'd0, SPI_CTRL}, {23'd0, c | 9'h002});
    end
    tick();
    chk("wait_ctrl", {23'd0, SPI_CTRL}, {23'd0, c});
    if (drop) req_valid[g] = 1'b0;
    if (stale) begin
      for (int s = 0; s < 6; s++) begin
        tick();
        chk("stale_no_rsp", {28'd0, rsp_valid}, 32'd0);
      end
      IRQ_SPI = 1'b0;
      tick();
    end
    SPI_DATA_IN = din_t[g];
    IRQ_SPI     = 1'b1;
    tick();
    chk("rsp_not_early", {28'd0, rsp_valid}, 32'd0);
    tick();
    chk("rsp_valid", {28'd0, rsp_valid}, 32'd1 << g);
    chk("rsp_data", rsp_data, din_t[g]);
    chk("rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("done_grant", {28'd0, grant}, 32'd0);
    chk("done_ctrl", {23'd0, SPI_CTRL}, 32'd0);
    IRQ_SPI      = 1'b0;
    req_valid[g] = 1'b0;
    $display("xfer req=%0d data_out=%h rsp_valid=%b rsp_data=%h err=%0d",
             g, SPI_DATA_OUT, rsp_valid, rsp_data, rsp_err);
  endtask

  initial begin
    int g;
    int n;
    logic [7:0] ord;
    logic [3:0] left;

    data_t[0] = 32'd9;          ctrl_t[0] = 9'b100000101; br_t[0] = 32'd2; din_t[0] = 32'h5;
    data_t[1] = 32'h1111_0001;  ctrl_t[1] = 9'h0FF;       br_t[1] = 32'd10; din_t[1] = 32'hCAFE_0001;
    data_t[2] = 32'h2222_0002;  ctrl_t[2] = 9'h155;       br_t[2] = 32'd3;  din_t[2] = 32'hDEAD_0002;
    data_t[3] = 32'h3333_0003;  ctrl_t[3] = 9'h0A8;       br_t[3] = 32'd7;  din_t[3] = 32'hBEEF_0003;
    for (int i = 0; i < N; i++) begin
      req_data[i*32 +: 32]    = data_t[i];
      req_bitrate[i*32 +: 32] = br_t[i];
      req_ctrl[i*9 +: 9]      = ctrl_t[i];
    end

    ph[0] = '{rst_first: 1'b0, mask: 4'b0001, rereq: 4'b0000, n: 1, order: 8'h00};
    ph[1] = '{rst_first: 1'b1, mask: 4'b1011, rereq: 4'b0001, n: 4, order: 8'h34};
    ph[2] = '{rst_first: 1'b0, mask: 4'b1111, rereq: 4'b0000, n: 4, order: 8'h39};
    ph[3] = '{rst_first: 1'b0, mask: 4'b1100, rereq: 4'b1000, n: 3, order: 8'h3E};

    req_valid   = '0;
    SPI_DATA_IN = '0;
    IRQ_SPI     = 1'b0;
    rst         = 1'b1;
    #3;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_bitrate", SPI_BITRATE, 32'd0);
    chk("rst_data_out", SPI_DATA_OUT, 32'd0);
    chk("rst_ctrl", {23'd0, SPI_CTRL}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Table-driven round-robin phases
    for (int p = 0; p < 4; p++) begin
      if (ph[p].rst_first) do_reset();
      ord = ph[p].order;
      for (int j = 0; j < ph[p].n; j++) exp_q.push_back(int'(ord[2*j +: 2]));
      left = ph[p].rereq;
      req_valid = req_valid | ph[p].mask;
      while (exp_q.size() > 0) begin
        do_xfer(1'b0, 1'b0, g);
        if (left[g]) begin
          req_valid[g] = 1'b1;
          left[g]      = 1'b0;
        end
      end
      tick();
    end

    // Stale IRQ: the level is already high before the grant (rr_ptr = 0)
    IRQ_SPI = 1'b1;
    tick();
    tick();
    req_valid = 4'b0010;
    exp_q.push_back(1);
    do_xfer(1'b1, 1'b0, g);
    tick();

    // Drop req_valid while in WAIT: the response is still delivered
    req_valid = 4'b0100;
    exp_q.push_back(2);
    do_xfer(1'b0, 1'b1, g);
    tick();

    // Reset while in WAIT
    req_valid = 4'b1000;
    wait_grant(n);
    chk("mid_grant", {28'd0, grant}, 32'b1000);
    for (int s = 0; s < SH + 3; s++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", {28'd0, grant}, 32'd0);
    chk("mid_rst_ctrl", {23'd0, SPI_CTRL}, 32'd0);
    chk("mid_rst_bitrate", SPI_BITRATE, 32'd0);
    chk("mid_rst_data_out", SPI_DATA_OUT, 32'd0);
    chk("mid_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
    req_valid = 4'b0001;
    exp_q.push_back(0);
    do_xfer(1'b0, 1'b0, g);
    tick();

    // No IRQ at all (rr_ptr = 1)
    req_valid = 4'b0010;
    wait_grant(n);
    chk("tmo_grant", {28'd0, grant}, 32'b0010);
    n = 0;
    while (rsp_valid == '0 && n < 1000) begin
      tick();
      n++;
    end
`ifdef SPI_ARB_TIMEOUT_EN
    chk("tmo_cycles", n, 19);
    chk("tmo_rsp_valid", {28'd0, rsp_valid}, 32'b0010);
    chk("tmo_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("tmo_rsp_data", rsp_data, 32'd0);
    chk("tmo_ctrl", {23'd0, SPI_CTRL}, 32'd0);
    $display("xfer req=1 timeout rsp_valid=%b err=%0d after %0d cycles", rsp_valid, rsp_err, n);
`else
    chk("no_tmo_rsp", {28'd0, rsp_valid}, 32'd0);
    chk("no_tmo_grant_held", {28'd0, grant}, 32'b0010);
    $display("xfer req=1 no response after %0d cycles", n);
`endif
    req_valid = '0;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
